// File: rtl/fp_pack_pkg.sv
// fp_pkg: shared binary32 field constants, packer widths and the packed word type.
// No ports. Optional feature macro used by the packer: FP_PACK_FLAGS_EN.
package fp_pkg;

    // binary32 layout
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned BIAS     = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;

    // Packer input format and internal widths
    localparam int unsigned EXP_IN_W  = 10;           // signed biased exponent
    localparam int unsigned MANT_IN_W = 28;           // carry,hidden,frac[23],G,R,S
    localparam int unsigned NORM_W    = 27;           // hidden,frac[23],G,R,S
    localparam int unsigned LZ_W      = 5;
    localparam int unsigned EXPX_W    = EXP_IN_W + 1; // room for +1 / -lz
    localparam int unsigned FLAGS_W   = 3;            // {overflow, underflow, inexact}

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_pack_if.sv
// fp_pack_if: input result bus and packed-word output bus of the packer.
//   master: producer of results / consumer of packed words (testbench or datapath)
//   slave : the packer
//   in_valid/in_ready/in_sign/in_exp/in_mant : unnormalized result handshake
//   out_valid/out_ready/out_word             : packed binary32 handshake
//   out_flags (only with FP_PACK_FLAGS_EN)   : {overflow, underflow, inexact}
interface fp_pack_if;
    import fp_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic [EXP_IN_W-1:0]  in_exp;
    logic [MANT_IN_W-1:0] in_mant;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_word;
`ifdef FP_PACK_FLAGS_EN
    logic [FLAGS_W-1:0]   out_flags;

    modport master (output in_valid, in_sign, in_exp, in_mant, out_ready,
                    input  in_ready, out_valid, out_word, out_flags);
    modport slave  (input  in_valid, in_sign, in_exp, in_mant, out_ready,
                    output in_ready, out_valid, out_word, out_flags);
`else
    modport master (output in_valid, in_sign, in_exp, in_mant, out_ready,
                    input  in_ready, out_valid, out_word);
    modport slave  (input  in_valid, in_sign, in_exp, in_mant, out_ready,
                    output in_ready, out_valid, out_word);
`endif

endinterface

// File: rtl/fp_pack_lzc.sv
// fp_lzc: combinational leading-zero counter over 27 bits.
//   i_val : value to scan from bit 26 downwards
//   o_cnt : number of leading zeros (27 when i_val is zero)
module fp_lzc
    import fp_pkg::*;
(
    input  logic [NORM_W-1:0] i_val,
    output logic [LZ_W-1:0]   o_cnt
);

    // Ascending scan: the highest set bit is the last to write o_cnt
    always_comb begin
        o_cnt = LZ_W'(NORM_W);
        for (int i = 0; i < int'(NORM_W); i++) begin
            if (i_val[i]) begin
                o_cnt = LZ_W'(int'(NORM_W) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_pack.sv
// fp_pack: two-stage normalize / round-to-nearest-even / pack into binary32.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fp_pack_if.slave (input result handshake, packed word output)
// Optional macro FP_PACK_FLAGS_EN adds bus.out_flags = {overflow, underflow, inexact}.
module fp_pack
    import fp_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    fp_pack_if.slave     bus
);

    localparam logic signed [EXPX_W-1:0] EXP_OVF = EXPX_W'(255);
    localparam logic signed [EXPX_W-1:0] EXP_UNF = EXPX_W'(0);

    // Pipeline state
    logic                      r_s1_valid;
    logic                      r_s1_sign;
    logic signed [EXPX_W-1:0]  r_s1_exp;
    logic [NORM_W-1:0]         r_s1_mant;
    logic                      r_s2_valid;
    fp32_t                     r_word;

    // Handshake: a stage advances when empty or when the stage after it advances
    logic w_s2_adv;
    logic w_s1_en;
    assign w_s2_adv     = !r_s2_valid || bus.out_ready;
    assign w_s1_en      = !r_s1_valid || w_s2_adv;
    assign bus.in_ready = w_s1_en;

    // Stage 1: normalize so the hidden bit lands on bit 26
    logic [LZ_W-1:0]          w_lz;
    logic [NORM_W-1:0]        w_n_mant;
    logic signed [EXPX_W-1:0] w_n_exp;

    fp_lzc u_lzc (
        .i_val (bus.in_mant[NORM_W-1:0]),
        .o_cnt (w_lz)
    );

    always_comb begin
        w_n_exp  = {bus.in_exp[EXP_IN_W-1], bus.in_exp};
        w_n_mant = bus.in_mant[NORM_W-1:0];
        if (bus.in_mant[MANT_IN_W-1]) begin
            // Carry: shift right one, the dropped bit folds into sticky
            w_n_mant = {bus.in_mant[MANT_IN_W-1:2], bus.in_mant[1] | bus.in_mant[0]};
            w_n_exp  = w_n_exp + EXPX_W'(1);
        end else begin
            w_n_mant = bus.in_mant[NORM_W-1:0] << w_lz;
            w_n_exp  = w_n_exp - EXPX_W'(w_lz);
        end
    end

    // Stage 2: round-to-nearest-even, range check, pack.
    // A normalized nonzero value always has the hidden bit set, so a clear
    // hidden bit identifies the zero input.
    logic                     w_zero;
    logic                     w_round_up;
    logic                     w_carry;
    logic [FRAC_W-1:0]        w_frac;
    logic signed [EXPX_W-1:0] w_exp_f;
    logic                     w_ovf;
    logic                     w_unf;
    logic                     w_inexact;
    fp32_t                    w_word;

    always_comb begin
        w_zero     = !r_s1_mant[NORM_W-1];
        w_round_up = r_s1_mant[2] & (r_s1_mant[1] | r_s1_mant[0] | r_s1_mant[3]);
        // Fraction wraps to zero on 1.111.. round-up; the carry bumps the exponent
        w_carry    = w_round_up & (&r_s1_mant[NORM_W-2:3]);
        w_frac     = r_s1_mant[NORM_W-2:3] + FRAC_W'(w_round_up);
        w_exp_f    = r_s1_exp + EXPX_W'(w_carry);
        w_ovf      = !w_zero && (w_exp_f >= EXP_OVF);
        w_unf      = !w_zero && (w_exp_f <= EXP_UNF);
        w_inexact  = (|r_s1_mant[2:0]) | w_ovf | w_unf;

        w_word = '{sign: r_s1_sign, exp: w_exp_f[EXP_W-1:0], frac: w_frac};
        if (w_zero || w_unf) begin
            w_word = '{sign: r_s1_sign, exp: '0, frac: '0};
        end else if (w_ovf) begin
            w_word = fp32_t'(r_s1_sign ? NEG_INF : POS_INF);
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_mant  <= '0;
            r_s2_valid <= 1'b0;
            r_word     <= '0;
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_sign <= bus.in_sign;
                    r_s1_exp  <= w_n_exp;
                    r_s1_mant <= w_n_mant;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_word <= w_word;
                end
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_word  = r_word;

`ifdef FP_PACK_FLAGS_EN
    // Flags travel with the word and hold under the same stall rule
    logic [FLAGS_W-1:0] r_flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_flags <= {w_ovf, w_unf, w_inexact};
        end
    end

    assign bus.out_flags = r_flags;
`endif

endmodule

// File: tb/tb_fp_pack.sv
// tb_fp_pack: directed scoreboard bench for fp_pack (flags checked when
// FP_PACK_FLAGS_EN is defined).
module tb_fp_pack;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_pack_if bus ();

    fp_pack u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Scoreboard: expected word/flags/tag/accept-cycle per accepted input
    logic [31:0] q_word [$];
    logic [2:0]  q_flags[$];
    string       q_tag  [$];
    int          q_cyc  [$];

    int          n_chk   = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    bit          lat_chk = 1'b1;
    logic [31:0] cur_word;
    logic [2:0]  cur_flags;
    string       cur_tag;
    bit          acc;
    bit          dlv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at negedge, score outputs, record accepts
    task automatic tick(output bit a, output bit d);
        string t;
        int    c;
        @(negedge clk);
        cyc++;
        a = bus.in_valid && bus.in_ready;
        d = bus.out_valid && bus.out_ready;
        if (d) begin
            if (q_word.size() == 0) begin
                n_chk++;
                $error("FAIL unexpected_out: observed %h expected no output", bus.out_word);
            end else begin
                t = q_tag.pop_front();
                c = q_cyc.pop_front();
                check({t, "_word"}, bus.out_word, q_word.pop_front());
`ifdef FP_PACK_FLAGS_EN
                check({t, "_flags"}, 32'(bus.out_flags), 32'(q_flags.pop_front()));
`else
                void'(q_flags.pop_front());
`endif
                if (lat_chk) check({t, "_latency"}, 32'(cyc - c), 32'd2);
            end
        end
        if (a) begin
            q_word.push_back(cur_word);
            q_flags.push_back(cur_flags);
            q_tag.push_back(cur_tag);
            q_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input string tag, input logic s, input logic [9:0] e,
                         input logic [27:0] m, input logic [31:0] w, input logic [2:0] f);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        cur_word     = w;
        cur_flags    = f;
        cur_tag      = tag;
    endtask

    task automatic send(input string tag, input logic s, input logic [9:0] e,
                        input logic [27:0] m, input logic [31:0] w, input logic [2:0] f);
        bit a;
        bit d;
        int n;
        drive(tag, s, e, m, w, f);
        a = 1'b0;
        n = 0;
        while (!a && n < 20) begin
            tick(a, d);
            n++;
        end
        if (!a) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit a;
        bit d;
        int n;
        n = 0;
        while (q_word.size() != 0 && n < 20) begin
            tick(a, d);
            n++;
        end
        check("drain_pending", 32'(q_word.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_word",  bus.out_word, 32'h0);
        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
`ifdef FP_PACK_FLAGS_EN
        check("rst_flags", 32'(bus.out_flags), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Back-to-back stream with out_ready=1: latency 2 and 1 word/cycle
        lat_chk = 1'b1;
        send("one",      1'b0, 10'd127, 28'h4000000, 32'h3F800000, 3'b000);
        send("carry",    1'b0, 10'd127, 28'h8000000, 32'h40000000, 3'b000);
        send("lz3",      1'b0, 10'd127, 28'h0800000, 32'h3E000000, 3'b000);
        send("tie_even", 1'b0, 10'd127, 28'h4000004, 32'h3F800000, 3'b001);
        send("tie_odd",  1'b0, 10'd127, 28'h400000C, 32'h3F800002, 3'b001);
        send("above",    1'b0, 10'd127, 28'h4000005, 32'h3F800001, 3'b001);
        send("ovf_rnd",  1'b0, 10'd254, 28'h7FFFFFC, 32'h7F800000, 3'b101);
        send("unf",      1'b1, 10'd0,   28'h4000000, 32'h80000000, 3'b011);
        send("zero",     1'b1, 10'd127, 28'h0000000, 32'h80000000, 3'b000);
        send("neg_exp",  1'b0, 10'h3FB, 28'h4000000, 32'h00000000, 3'b011);
        send("ovf_neg",  1'b1, 10'd300, 28'h4000000, 32'hFF800000, 3'b101);
        send("lz23",     1'b0, 10'd127, 28'h0000008, 32'h34000000, 3'b000);
        send("carry_st", 1'b0, 10'd127, 28'h8000001, 32'h40000000, 3'b001);
        drain();

        // Backpressure: two accepts fill the pipe, third stalls, output holds
        lat_chk       = 1'b0;
        bus.out_ready = 1'b0;
        drive("bp0", 1'b0, 10'd127, 28'h4000000, 32'h3F800000, 3'b000);
        tick(acc, dlv);
        check("bp_accept0", 32'(acc), 32'd1);
        drive("bp1", 1'b0, 10'd127, 28'h8000000, 32'h40000000, 3'b000);
        tick(acc, dlv);
        check("bp_accept1", 32'(acc), 32'd1);
        drive("bp2", 1'b0, 10'd127, 28'h0800000, 32'h3E000000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick(acc, dlv);
            check("bp_stall_accept", 32'(acc), 32'd0);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_word", bus.out_word, 32'h3F800000);
        end
        bus.out_ready = 1'b1;
        tick(acc, dlv);
        check("bp_accept2", 32'(acc), 32'd1);
        check("bp_emit0", 32'(dlv), 32'd1);
        bus.in_valid = 1'b0;
        tick(acc, dlv);
        check("bp_emit1", 32'(dlv), 32'd1);
        tick(acc, dlv);
        check("bp_emit2", 32'(dlv), 32'd1);
        check("bp_queue_empty", 32'(q_word.size()), 32'd0);

        // Reset with two words in flight drops both
        bus.out_ready = 1'b0;
        send("rs0", 1'b0, 10'd127, 28'h4000000, 32'h3F800000, 3'b000);
        send("rs1", 1'b0, 10'd127, 28'h8000000, 32'h40000000, 3'b000);
        check("rs_inflight_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        q_word.delete();
        q_flags.delete();
        q_tag.delete();
        q_cyc.delete();
        rst_n = 1'b1;
        check("rs_out_valid", 32'(bus.out_valid), 32'd0);
        check("rs_in_ready",  32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(acc, dlv);
            check("rs_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Pipeline still works after the mid-flight reset
        lat_chk = 1'b1;
        send("post_rs", 1'b0, 10'd127, 28'h400000C, 32'h3F800002, 3'b001);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
